// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mandel_pkg
// Purpose  : shared widths, default screen size and dispatcher state encoding
// Revision : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int c_COLOR_W       = 24;
    localparam int c_COORD_W       = 11;
    localparam int c_DEFAULT_H_RES = 640;
    localparam int c_DEFAULT_V_RES = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_OUT   = 3'd4
    } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Interface: pixel_dispatcher_if
// Purpose  : engine start/done channel plus the outgoing valid/ready pixel stream
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_dispatcher_if #(
    parameter int WORD_LENGTH = 64
);

    logic                               start;
    logic [mandel_pkg::c_COORD_W-1:0]   x;
    logic [mandel_pkg::c_COORD_W-1:0]   y;
    logic [WORD_LENGTH-1:0]             re_c;
    logic [WORD_LENGTH-1:0]             im_c;
    logic                               done;
    logic [mandel_pkg::c_COLOR_W-1:0]   color;
    logic [mandel_pkg::c_COLOR_W-1:0]   pix_data;
    logic                               pix_valid;
    logic                               pix_ready;
    logic                               pix_sof;
    logic                               pix_eol;

    modport master (
        output start, x, y, re_c, im_c,
        input  done, color,
        output pix_data, pix_valid, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  start, x, y, re_c, im_c,
        output done, color,
        input  pix_data, pix_valid, pix_sof, pix_eol,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/coord_stepper.sv
`default_nettype none
// ============================================================================
// Module   : coord_stepper
// Purpose  : raster x/y counters with Re/Im accumulators stepped by addition only
// Revision : 1.0 - initial release
// ============================================================================
module coord_stepper
    import mandel_pkg::*;
#(
    parameter int WORD_LENGTH = 64,
    parameter int H_RES       = c_DEFAULT_H_RES,
    parameter int V_RES       = c_DEFAULT_V_RES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic                    i_advance,
    input  logic [WORD_LENGTH-1:0]  i_re_origin,
    input  logic [WORD_LENGTH-1:0]  i_im_origin,
    input  logic [WORD_LENGTH-1:0]  i_step,
    output logic [c_COORD_W-1:0]    o_x,
    output logic [c_COORD_W-1:0]    o_y,
    output logic [WORD_LENGTH-1:0]  o_re,
    output logic [WORD_LENGTH-1:0]  o_im,
    output logic                    o_last_x,
    output logic                    o_last_pixel
);

    localparam logic [c_COORD_W-1:0] c_X_LAST = c_COORD_W'(H_RES - 1);
    localparam logic [c_COORD_W-1:0] c_Y_LAST = c_COORD_W'(V_RES - 1);

    logic [c_COORD_W-1:0]   r_x;
    logic [c_COORD_W-1:0]   r_y;
    logic [WORD_LENGTH-1:0] r_re;
    logic [WORD_LENGTH-1:0] r_im;
    logic [WORD_LENGTH-1:0] r_re_origin;
    logic [WORD_LENGTH-1:0] r_step;

    // Origin and step are captured once per frame so input changes mid-frame are inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_re_origin <= '0;
            r_step      <= '0;
        end else if (i_load) begin
            r_x         <= '0;
            r_y         <= '0;
            r_re        <= i_re_origin;
            r_im        <= i_im_origin;
            r_re_origin <= i_re_origin;
            r_step      <= i_step;
        end else if (i_advance) begin
            if (r_x != c_X_LAST) begin
                r_x  <= r_x + 1'b1;
                r_re <= r_re + r_step;
            end else begin
                r_x  <= '0;
                r_re <= r_re_origin;
                r_y  <= r_y + 1'b1;
                r_im <= r_im - r_step;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_re         = r_re;
    assign o_im         = r_im;
    assign o_last_x     = (r_x == c_X_LAST);
    assign o_last_pixel = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pixel_dispatcher
// Purpose  : raster-scans a frame, runs the Mandelbrot engine per pixel and
//            streams the returned colours with SOF/EOL markers
// Revision : 1.0 - initial release
// ============================================================================
module pixel_dispatcher
    import mandel_pkg::*;
#(
    parameter int FRAC        = 60,
    parameter int WORD_LENGTH = 64,
    parameter int H_RES       = c_DEFAULT_H_RES,
    parameter int V_RES       = c_DEFAULT_V_RES
) (
    input  logic                    sysclk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic [WORD_LENGTH-1:0]  re_origin,
    input  logic [WORD_LENGTH-1:0]  im_origin,
    input  logic [WORD_LENGTH-1:0]  step,
    output logic                    busy,
    pixel_dispatcher_if.master      bus
);

    if (FRAC >= WORD_LENGTH || H_RES < 1 || V_RES < 1 || H_RES > 2048 || V_RES > 2048) begin : g_param_check
        $error("pixel_dispatcher: unsupported FRAC/WORD_LENGTH/H_RES/V_RES combination");
    end

    disp_state_t            r_state;
    logic                   r_start;
    logic                   r_busy;
    logic                   r_pix_valid;
    logic                   r_pix_sof;
    logic                   r_pix_eol;
    logic [c_COLOR_W-1:0]   r_pix_data;

    logic                   w_load;
    logic                   w_advance;
    logic [c_COORD_W-1:0]   w_x;
    logic [c_COORD_W-1:0]   w_y;
    logic [WORD_LENGTH-1:0] w_re;
    logic [WORD_LENGTH-1:0] w_im;
    logic                   w_last_x;
    logic                   w_last_pixel;

    assign w_load    = (r_state == ST_IDLE) && frame_start;
    // pix_valid is high for the whole OUT state, so ready alone completes the handshake.
    assign w_advance = (r_state == ST_OUT) && bus.pix_ready;

    coord_stepper #(
        .WORD_LENGTH (WORD_LENGTH),
        .H_RES       (H_RES),
        .V_RES       (V_RES)
    ) u_coord_stepper (
        .clk          (sysclk),
        .rst_n        (reset_n),
        .i_load       (w_load),
        .i_advance    (w_advance),
        .i_re_origin  (re_origin),
        .i_im_origin  (im_origin),
        .i_step       (step),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_re         (w_re),
        .o_im         (w_im),
        .o_last_x     (w_last_x),
        .o_last_pixel (w_last_pixel)
    );

    // start is raised on entry to ISSUE so it is high for exactly the ISSUE cycle;
    // done is never looked at in ISSUE, which masks a level-held done from the last pixel.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_sof   <= 1'b0;
            r_pix_eol   <= 1'b0;
            r_pix_data  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.done) begin
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    r_pix_data  <= bus.color;
                    r_pix_sof   <= (w_x == '0) && (w_y == '0);
                    r_pix_eol   <= w_last_x;
                    r_pix_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (w_last_pixel) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign bus.start     = r_start;
    assign bus.x         = w_x;
    assign bus.y         = w_y;
    assign bus.re_c      = w_re;
    assign bus.im_c      = w_im;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_sof   = r_pix_sof;
    assign bus.pix_eol   = r_pix_eol;

endmodule
`default_nettype wire

// File: tb/tb_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_dispatcher
// Purpose  : self-checking bench with engine model, pixel sink and frame model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_dispatcher;
    import mandel_pkg::*;

    localparam int H      = 4;
    localparam int V      = 2;
    localparam int WL     = 64;
    localparam int NPIX   = H * V;
    localparam int BUDGET = 2000;

    localparam logic [63:0] RE0   = 64'hE000_0000_0000_0000;
    localparam logic [63:0] IM0   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] STEP0 = 64'h0800_0000_0000_0000;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [63:0] re;
        logic [63:0] im;
        int          cyc;
    } start_rec_t;

    typedef struct {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        int          cyc;
    } pix_rec_t;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [63:0] re;
        logic [63:0] im;
        logic        sof;
        logic        eol;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [63:0] re_origin;
    logic [63:0] im_origin;
    logic [63:0] step;
    logic        busy;

    start_rec_t  starts[$];
    pix_rec_t    pixels[$];
    vec_t        tbl[NPIX];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          start_cnt = 0;
    int          fs_cyc = 0;
    int          busy_fall_cyc = 0;
    int          eng_lat = 3;
    bit          eng_hold = 1'b0;
    int          rdy_mode = 0;
    int          stall_px = 0;
    int          stall_len = 0;
    int          stall_done = 0;
    logic [3:0]  salt = 4'hA;

    pixel_dispatcher_if #(.WORD_LENGTH(WL)) bus ();

    pixel_dispatcher #(
        .FRAC        (60),
        .WORD_LENGTH (WL),
        .H_RES       (H),
        .V_RES       (V)
    ) dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .re_origin   (re_origin),
        .im_origin   (im_origin),
        .step        (step),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 sysclk = ~sysclk;

    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    function automatic logic [23:0] color_of(input logic [10:0] px, input logic [10:0] py);
        return {salt, px[9:0], py[9:0]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Engine: done 'eng_lat' cycles after start, or held high permanently.
    initial begin : engine
        int          cnt;
        logic [10:0] ex;
        logic [10:0] ey;
        cnt = 0;
        ex = '0;
        ey = '0;
        bus.done = 1'b0;
        bus.color = '0;
        forever begin
            @(posedge sysclk);
            #1;
            if (eng_hold) begin
                bus.done = 1'b1;
                bus.color = color_of(bus.x, bus.y);
                cnt = 0;
            end else begin
                bus.done = 1'b0;
                if (bus.start) begin
                    cnt = eng_lat;
                    ex = bus.x;
                    ey = bus.y;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.done = 1'b1;
                        bus.color = color_of(ex, ey);
                    end
                end
            end
        end
    end

    initial begin : sink
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge sysclk);
            #1;
            case (rdy_mode)
                1:       bus.pix_ready = ($urandom_range(0, 99) < 65);
                2:       bus.pix_ready = !(hs_cnt == stall_px && stall_done < stall_len);
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    // Observes starts and handshakes; also checks the stream hold and single-cycle start rules.
    initial begin : monitor
        logic        pv, pstart, pbusy, psof, peol, phs;
        logic [23:0] pdata;
        start_rec_t  srec;
        pix_rec_t    prec;
        pv = 0; pstart = 0; pbusy = 0; psof = 0; peol = 0; phs = 0; pdata = '0;
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                pv = 0; pstart = 0; pbusy = 0; phs = 0;
            end else begin
                if (bus.start) begin
                    srec.x = bus.x; srec.y = bus.y; srec.re = bus.re_c; srec.im = bus.im_c; srec.cyc = cyc;
                    starts.push_back(srec);
                    start_cnt++;
                    chk("start_one_cycle", pstart, 1'b0);
                    chk("start_while_valid", bus.pix_valid, 1'b0);
                end
                if (pv && !phs) begin
                    chk("stall_hold", {bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_data},
                                      {1'b1, psof, peol, pdata});
                end
                phs = bus.pix_valid && bus.pix_ready;
                if (phs) begin
                    prec.data = bus.pix_data; prec.sof = bus.pix_sof; prec.eol = bus.pix_eol; prec.cyc = cyc;
                    pixels.push_back(prec);
                    hs_cnt++;
                end
                if (bus.pix_valid && !bus.pix_ready && rdy_mode == 2) stall_done++;
                if (pbusy && !busy) busy_fall_cyc = cyc;
                pv = bus.pix_valid; pdata = bus.pix_data; psof = bus.pix_sof; peol = bus.pix_eol;
                pstart = bus.start; pbusy = busy;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {busy, bus.start, bus.pix_valid, bus.pix_sof, bus.pix_eol}, 5'b0);
        chk({tag, "_xy"}, {bus.x, bus.y}, 22'b0);
        chk({tag, "_re_im"}, {bus.re_c, bus.im_c}, 128'b0);
        chk({tag, "_data"}, bus.pix_data, 24'b0);
    endtask

    task automatic clear_logs();
        starts.delete();
        pixels.delete();
        hs_cnt = 0;
        start_cnt = 0;
        stall_done = 0;
    endtask

    task automatic run_frame(input logic [63:0] re_o, input logic [63:0] im_o,
                             input logic [63:0] st, input bit mid_pulse);
        bit pulsed;
        bit fin;
        pulsed = 0;
        fin = 0;
        clear_logs();
        @(posedge sysclk);
        #1;
        re_origin = re_o; im_origin = im_o; step = st;
        frame_start = 1'b1;
        fs_cyc = cyc;
        for (int n = 0; n < BUDGET; n++) begin
            @(posedge sysclk);
            #1;
            frame_start = 1'b0;
            if (mid_pulse && !pulsed && hs_cnt >= 3) begin
                frame_start = 1'b1;
                re_origin = ~re_o;
                im_origin = 64'h0;
                step = st << 1;
                pulsed = 1;
            end
            if (!busy) begin
                fin = 1;
                break;
            end
        end
        frame_start = 1'b0;
        chk("frame_complete", fin, 1'b1);
        @(negedge sysclk);
        #1;
    endtask

    // Reference: pixel i sits at column i%H, row i/H; c = origin + col*step - j*row*step.
    task automatic compare_frame(input string tag, input logic [63:0] re_o,
                                 input logic [63:0] im_o, input logic [63:0] st);
        chk({tag, "_start_count"}, starts.size(), NPIX);
        chk({tag, "_pixel_count"}, pixels.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            int          px;
            int          py;
            logic [63:0] er;
            logic [63:0] ei;
            px = i % H;
            py = i / H;
            er = re_o + 64'(px) * st;
            ei = im_o - 64'(py) * st;
            if (i < starts.size()) begin
                chk($sformatf("%s_coord%0d", tag, i),
                    {starts[i].x, starts[i].y, starts[i].re, starts[i].im},
                    {11'(px), 11'(py), er, ei});
            end
            if (i < pixels.size()) begin
                chk($sformatf("%s_pix%0d", tag, i),
                    {pixels[i].sof, pixels[i].eol, pixels[i].data},
                    {(i == 0), (px == H - 1), color_of(11'(px), 11'(py))});
            end
        end
    endtask

    initial begin : main
        bit found;

        tbl[0] = '{11'd0, 11'd0, 64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b1, 1'b0};
        tbl[1] = '{11'd1, 11'd0, 64'hE800_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1'b0};
        tbl[2] = '{11'd2, 11'd0, 64'hF000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1'b0};
        tbl[3] = '{11'd3, 11'd0, 64'hF800_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1'b1};
        tbl[4] = '{11'd0, 11'd1, 64'hE000_0000_0000_0000, 64'h0800_0000_0000_0000, 1'b0, 1'b0};
        tbl[5] = '{11'd1, 11'd1, 64'hE800_0000_0000_0000, 64'h0800_0000_0000_0000, 1'b0, 1'b0};
        tbl[6] = '{11'd2, 11'd1, 64'hF000_0000_0000_0000, 64'h0800_0000_0000_0000, 1'b0, 1'b0};
        tbl[7] = '{11'd3, 11'd1, 64'hF800_0000_0000_0000, 64'h0800_0000_0000_0000, 1'b0, 1'b1};

        reset_n = 1'b0;
        frame_start = 1'b0;
        re_origin = '0;
        im_origin = '0;
        step = '0;
        repeat (3) @(posedge sysclk);
        #1;
        check_reset_outputs("reset_init");
        @(posedge sysclk);
        #1;
        reset_n = 1'b1;

        // 1: nominal frame against the fixed vector table, with cycle-exact timing.
        eng_lat = 3; rdy_mode = 0;
        run_frame(RE0, IM0, STEP0, 1'b0);
        chk("t1_start_count", starts.size(), NPIX);
        chk("t1_pixel_count", pixels.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < starts.size() && i < pixels.size()) begin
                chk($sformatf("t1_coord%0d", i),
                    {starts[i].x, starts[i].y, starts[i].re, starts[i].im},
                    {tbl[i].x, tbl[i].y, tbl[i].re, tbl[i].im});
                chk($sformatf("t1_pix%0d", i),
                    {pixels[i].sof, pixels[i].eol, pixels[i].data},
                    {tbl[i].sof, tbl[i].eol, color_of(tbl[i].x, tbl[i].y)});
                chk($sformatf("t1_valid_latency%0d", i), pixels[i].cyc - starts[i].cyc, 5);
                if (i > 0) chk($sformatf("t1_spacing%0d", i), starts[i].cyc - starts[i-1].cyc, 6);
            end
        end
        if (starts.size() > 0) chk("t1_first_start", starts[0].cyc, fs_cyc + 1);
        if (pixels.size() > 0) chk("t1_busy_fall", busy_fall_cyc, pixels[pixels.size()-1].cyc + 1);

        // 2: hold ready low for 5 cycles on pixel 2.
        rdy_mode = 2; stall_px = 2; stall_len = 5;
        run_frame(RE0, IM0, STEP0, 1'b0);
        compare_frame("t2", RE0, IM0, STEP0);
        chk("t2_stall_cycles", stall_done, 5);
        if (starts.size() > 2 && pixels.size() > 2)
            chk("t2_stall_delay", pixels[2].cyc - starts[2].cyc, 10);
        rdy_mode = 0;

        // 3: done held high: stale done in ISSUE must be ignored.
        eng_hold = 1'b1;
        run_frame(RE0, IM0, STEP0, 1'b0);
        compare_frame("t3", RE0, IM0, STEP0);
        for (int i = 1; i < starts.size(); i++)
            chk($sformatf("t3_spacing%0d", i), (starts[i].cyc - starts[i-1].cyc) >= 4, 1'b1);
        eng_hold = 1'b0;
        repeat (2) @(posedge sysclk);

        // 4: frame_start and new origin mid-frame are ignored.
        run_frame(RE0, IM0, STEP0, 1'b1);
        compare_frame("t4", RE0, IM0, STEP0);
        repeat (3) @(posedge sysclk);
        #1;
        chk("t4_no_queued_frame", {busy, 32'(starts.size())}, {1'b0, 32'(NPIX)});

        // 5: asynchronous reset during WAIT of pixel 5, then a fresh frame.
        clear_logs();
        @(posedge sysclk);
        #1;
        re_origin = RE0; im_origin = IM0; step = STEP0;
        frame_start = 1'b1;
        @(posedge sysclk);
        #1;
        frame_start = 1'b0;
        found = 0;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge sysclk);
            #1;
            if (start_cnt == 6) begin
                found = 1;
                break;
            end
        end
        chk("t5_reach_pixel5", found, 1'b1);
        @(posedge sysclk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        repeat (3) @(posedge sysclk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge sysclk);
        #1;
        chk("t5_idle_after_reset", {busy, bus.pix_valid}, 2'b00);
        run_frame(RE0, IM0, STEP0, 1'b0);
        compare_frame("t5", RE0, IM0, STEP0);
        if (starts.size() > 0 && pixels.size() > 0)
            chk("t5_first_pixel", {pixels[0].sof, starts[0].re}, {1'b1, RE0});

        // 6: accumulator wraps without saturation.
        run_frame(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 1'b0);
        compare_frame("t6", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h1);
        if (starts.size() > 1) chk("t6_wrap_re1", starts[1].re, 64'h8000_0000_0000_0000);

        // Randomised frames: origins, step, engine latency, downstream back-pressure.
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            logic [63:0] ro;
            logic [63:0] io;
            logic [63:0] so;
            ro = {$urandom, $urandom};
            io = {$urandom, $urandom};
            so = {$urandom, $urandom};
            eng_lat = $urandom_range(1, 5);
            salt = 4'($urandom_range(1, 15));
            run_frame(ro, io, so, 1'b0);
            compare_frame($sformatf("rnd%0d", r), ro, io, so);
        end
        rdy_mode = 0;

        repeat (2) @(posedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire

// File: doc/pixel_dispatcher.md
# pixel_dispatcher

Frame-level initiator for the per-pixel Mandelbrot engine (`depth_calculator` followed by `table_color`).
- Scans an H_RES × V_RES screen in raster order.
- For each pixel, derives the complex coordinate c from a latched origin and pixel step, issues a start/done transaction to the engine, and captures the returned 24-bit colour.
- Emits the colour as a valid/ready pixel stream with start-of-frame and end-of-line markers, toward the frame buffer / video side.

## Interface
Parameters:
- FRAC, 60, fractional bits of the signed fixed-point coordinate format.
- WORD_LENGTH, 64, coordinate word width.
- H_RES, 640, pixels per line (≤ 2048).
- V_RES, 480, lines per frame (≤ 2048).

Ports:
- sysclk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- re_origin  in  WORD_LENGTH  Re(c) of pixel (0,0), signed Q(WORD_LENGTH-FRAC).FRAC.
- im_origin  in  WORD_LENGTH  Im(c) of pixel (0,0), same format.
- step  in  WORD_LENGTH  pixel pitch in the same format; unsigned use.
- busy  out  1  high from frame acceptance until the last pixel is handshaken.
- start  out  1  one-cycle engine start strobe.
- x  out  11  engine pixel column.
- y  out  11  engine pixel row.
- re_c  out  WORD_LENGTH  engine Re(c).
- im_c  out  WORD_LENGTH  engine Im(c).
- done  in  1  engine completion.
- color  in  24  engine colour; valid the cycle after done is sampled.
- pix_data  out  24  output pixel colour.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  marks pixel (0,0); qualified by pix_valid.
- pix_eol  out  1  marks x = H_RES-1; qualified by pix_valid.

## Operation
FSM states: IDLE, ISSUE, WAIT, CAPT, OUT.

- **IDLE**: on frame_start, latch re_origin, im_origin and step. Set x=0, y=0, re_acc=re_origin, im_acc=im_origin, busy=1. Go to ISSUE.
- **ISSUE**: start=1 for exactly one cycle. x, y, re_c and im_c are driven from registers and held stable from ISSUE through CAPT. Go to WAIT.
- **WAIT**: done is sampled from the first WAIT cycle onward. done in the ISSUE cycle is ignored, which covers a level-held done from the previous pixel. On done=1, go to CAPT.
- **CAPT**: register color into pix_data; set pix_sof and pix_eol from x/y. Go to OUT.
- **OUT**: pix_valid=1; pix_data, pix_sof and pix_eol are held until pix_valid && pix_ready. On the handshake, advance coordinates:
  - If x < H_RES-1: x+1, re_acc += step.
  - Otherwise: x=0, re_acc=re_origin (latched copy), y+1, im_acc -= step.
  - After pixel (H_RES-1, V_RES-1): go to IDLE with busy=0. Otherwise go to ISSUE.
- Arithmetic: re_acc and im_acc are WORD_LENGTH-bit accumulators using two's-complement add/subtract. They wrap modulo 2^WORD_LENGTH, with no saturation. No multipliers.
- frame_start outside IDLE is ignored, with no queueing. A change to origin/step inputs mid-frame has no effect.
- Reset (any state, asynchronous) produces:
  - state=IDLE.
  - start, busy, pix_valid, pix_sof, pix_eol = 0.
  - x, y, re_c, im_c, pix_data = 0.
  - Any in-flight engine result is discarded.

## Timing
- Per-pixel cycles = 1 (ISSUE) + N (WAIT, N ≥ 1 including the done cycle) + 1 (CAPT) + M (OUT, M ≥ 1 until ready).
- With engine done high in WAIT cycle t, pix_valid rises at t+2. If pix_ready=1 then, the next start is at t+3.
- Outputs are registered, with no combinational path from done or pix_ready to any output.
- Frame acceptance: frame_start sampled at edge k → busy=1 and state ISSUE from k+1 → first start in cycle k+1.

## Structure
- Shared package mandel_pkg holds:
  - the dispatcher state enum;
  - default H_RES/V_RES constants;
  - the colour width (24) and coordinate width (11) localparams, reused by the engine.
- One sub-module, coord_stepper: x/y counters plus re/im accumulators, with load, advance and wrap outputs (last_x, last_pixel). The FSM stays in pixel_dispatcher.

## Test plan
Common setup: H_RES=4, V_RES=2, FRAC=60, WORD_LENGTH=64, re_origin=0xE000_0000_0000_0000 (−2.0), im_origin=0x1000_0000_0000_0000 (1.0), step=0x0800_0000_0000_0000 (0.5).

1. Engine model with done 3 cycles after start, pix_ready=1. Required response:
   - 8 pixels out.
   - Pixel 0 has re_c=−2.0, im_c=1.0, pix_sof=1.
   - Pixel 3 has re_c=−0.5 and pix_eol=1.
   - Pixel 4 has re_c=−2.0, im_c=0.5.
   - busy falls after the 8th handshake.
2. pix_ready held low for 5 cycles on pixel 2. Required response: pix_data, pix_sof and pix_eol are stable, and no new start is issued until the handshake.
3. Engine holds done high continuously. Required response: the stale done in the ISSUE cycle is ignored, and each pixel still takes ≥ 4 cycles.
4. frame_start pulsed mid-frame with different origin. Required response: frame continues with the original origin, and exactly 8 pixels are produced.
5. reset_n asserted during WAIT of pixel 5. Required response: all outputs go to 0 immediately. A subsequent frame_start produces pixel 0 with pix_sof=1 and re_c=−2.0.
6. re_origin=0x7FFF_FFFF_FFFF_FFFF, step=1. Required response: re_c of pixel 1 = 0x8000_0000_0000_0000 (wrap, no saturation).
